// File: rtl/ula_mult_4x4_seq.sv
// Sequential 4x4 unsigned shift-and-add multiplier that feeds ULA result mux slot 4.
// Optional macro ULA_MULT_EARLY_EXIT_EN ends the iteration once no multiplier bits remain.
module ula_mult_4x4_seq (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       START,
  output logic [7:0] P,
  output logic       BUSY,
  output logic       DONE
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t     state_q;
  logic [7:0] mcand_q;
  logic [3:0] mq_q;
  logic [7:0] acc_q;
  logic [1:0] cnt_q;
  logic [7:0] p_q;
  logic       busy_q;
  logic       done_q;

  logic [7:0] acc_d;
  logic [3:0] mq_d;
  logic       last_d;

  assign acc_d = acc_q + (mq_q[0] ? mcand_q : 8'h00);
  assign mq_d  = mq_q >> 1;

`ifdef ULA_MULT_EARLY_EXIT_EN
  // Remaining multiplier bits all zero: further iterations would add nothing.
  assign last_d = (cnt_q == 2'd3) || (mq_d == 4'h0);
`else
  assign last_d = (cnt_q == 2'd3);
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      mcand_q <= 8'h00;
      mq_q    <= 4'h0;
      acc_q   <= 8'h00;
      cnt_q   <= 2'd0;
      p_q     <= 8'h00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (START) begin
            mcand_q <= {4'h0, A};
            mq_q    <= B;
            acc_q   <= 8'h00;
            cnt_q   <= 2'd0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          acc_q   <= acc_d;
          mcand_q <= mcand_q << 1;
          mq_q    <= mq_d;
          cnt_q   <= cnt_q + 2'd1;
          if (last_d) begin
            p_q     <= acc_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          // START is deliberately not looked at here; requests are not queued.
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign P    = p_q;
  assign BUSY = busy_q;
  assign DONE = done_q;

endmodule

// File: tb/tb_ula_mult_4x4_seq.sv
// Self-checking bench for ula_mult_4x4_seq: directed and random products against A*B
// with latency derived from the multiplier's bit length.
module tb_ula_mult_4x4_seq;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [3:0] A = 4'h0;
  logic [3:0] B = 4'h0;
  logic       START = 1'b0;
  logic [7:0] P;
  logic       BUSY;
  logic       DONE;

  int checks = 0;
  int errors = 0;

  ula_mult_4x4_seq dut (
    .CLK(CLK), .RST(RST), .A(A), .B(B), .START(START),
    .P(P), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Move to just after the next rising edge; all driving and sampling happens there.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Cycles from accepting edge to DONE: full 4 iterations, or bit length of B with early exit.
  function automatic int exp_lat(input logic [3:0] b);
`ifdef ULA_MULT_EARLY_EXIT_EN
    int n;
    n = 1;
    for (int i = 0; i < 4; i++) if (b[i]) n = i + 1;
    return n;
`else
    return 4;
`endif
  endfunction

  // One operation from IDLE. noisy keeps START high with new operands during RUN and DONE.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input bit noisy);
    int lat;
    bit seen;
    logic [7:0] exp_p;
    exp_p = 8'(a * b);
    A = a; B = b; START = 1'b1;
    step();
    chk("busy_after_accept", BUSY, 1);
    chk("done_after_accept", DONE, 0);
    if (noisy) begin
      A = 4'd1; B = 4'd1;
    end else begin
      START = 1'b0;
      A = 4'($urandom_range(0, 15)); B = 4'($urandom_range(0, 15));
    end
    lat = 0;
    seen = 0;
    for (int c = 0; c < 8 && !seen; c++) begin
      step();
      lat++;
      chk("busy_done_exclusive", BUSY & DONE, 0);
      if (DONE) seen = 1;
    end
    chk("done_seen", seen, 1);
    chk("latency", lat, exp_lat(b));
    chk("product", P, exp_p);
    chk("busy_low_in_done", BUSY, 0);
    step();
    chk("done_one_cycle", DONE, 0);
    chk("product_hold", P, exp_p);
    START = 1'b0;
    if (noisy) begin
      for (int c = 0; c < 6; c++) begin
        step();
        chk("no_requeue_busy", BUSY, 0);
        chk("no_requeue_done", DONE, 0);
        chk("no_requeue_p", P, exp_p);
      end
    end
  endtask

  initial begin
    int per;
    int last_c;
    int pulses;
    #12;
    chk("reset_p", P, 0);
    chk("reset_busy", BUSY, 0);
    chk("reset_done", DONE, 0);
    @(negedge CLK);
    RST = 1'b0;
    step();

    // Largest operands, then hold through idle cycles.
    run_op(4'd15, 4'd15, 0);
    for (int c = 0; c < 10; c++) begin
      step();
      chk("idle_hold_p", P, 8'hE1);
      chk("idle_busy", BUSY, 0);
    end

    run_op(4'd3, 4'd5, 0);
    run_op(4'd7, 4'd0, 0);

    // START pulses during RUN and DONE are ignored.
    run_op(4'd9, 4'd9, 1);

    // START held high: back-to-back operations every latency+2 cycles.
    per = exp_lat(4'd3) + 2;
    A = 4'd2; B = 4'd3; START = 1'b1;
    last_c = -1;
    pulses = 0;
    for (int c = 0; c < 4 * per; c++) begin
      step();
      chk("held_exclusive", BUSY & DONE, 0);
      if (DONE) begin
        chk("held_p", P, 8'h06);
        if (last_c >= 0) chk("held_period", c - last_c, per);
        last_c = c;
        pulses++;
      end
    end
    chk("held_pulses_ge3", pulses >= 3, 1);
    START = 1'b0;
    for (int c = 0; c < 8; c++) step();
    chk("held_drained", BUSY | DONE, 0);

    // Asynchronous reset between e2 and e3.
    A = 4'd15; B = 4'd15; START = 1'b1;
    step();
    START = 1'b0;
    step();
    step();
    #2;
    RST = 1'b1;
    #1;
    chk("async_rst_p", P, 0);
    chk("async_rst_busy", BUSY, 0);
    chk("async_rst_done", DONE, 0);
    #1;
    RST = 1'b0;
    step();
    chk("post_rst_idle", BUSY, 0);
    run_op(4'd4, 4'd4, 0);

    // Early-exit boundary operands; also valid for the fixed-latency build.
    run_op(4'd15, 4'd1, 0);
    run_op(4'd15, 4'd8, 0);

    for (int k = 0; k < 12; k++)
      run_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

endmodule
